// File: rtl/freq_sweep_ctrl_if.sv
// Control/status bundle between a sweep requester and freq_sweep_ctrl.
// Signal names carry the block's pin names so the two sides read the same.
interface freq_sweep_ctrl_if #(
    parameter int ACCUM_LENGTH = 24,
    parameter int DWELL_WIDTH  = 16
);
    logic                    start_in;
    logic                    stop_in;
    logic                    tick_in;
    logic [1:0]              mode_in;
    logic [ACCUM_LENGTH-1:0] f_start_in;
    logic [ACCUM_LENGTH-1:0] f_stop_in;
    logic [ACCUM_LENGTH-1:0] f_step_in;
    logic [DWELL_WIDTH-1:0]  dwell_in;
    logic [ACCUM_LENGTH-1:0] freq_out;
    logic                    freq_upd_out;
    logic                    busy_out;
    logic                    done_out;
    logic                    err_out;

    modport master (
        output start_in, stop_in, tick_in, mode_in, f_start_in, f_stop_in, f_step_in, dwell_in,
        input  freq_out, freq_upd_out, busy_out, done_out, err_out
    );

    modport slave (
        input  start_in, stop_in, tick_in, mode_in, f_start_in, f_stop_in, f_step_in, dwell_in,
        output freq_out, freq_upd_out, busy_out, done_out, err_out
    );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep controller: steps a DDS tuning word from start to stop with a
// tick-counted dwell per point, in single-ramp, repeating-ramp or triangle mode.
module freq_sweep_ctrl #(
    parameter int ACCUM_LENGTH = 24,
    parameter int DWELL_WIDTH  = 16
) (
    input logic               clk_in,
    input logic               rst_in,
    freq_sweep_ctrl_if.slave  ctrl_io
);
    typedef enum logic [2:0] {StIdle, StLoad, StDwell, StStep, StDone} state_e;

    state_e                  state_q, state_d;
    logic [ACCUM_LENGTH-1:0] freq_q, freq_d;
    logic                    upd_q, upd_d;
    logic                    err_q, err_d;
    logic [DWELL_WIDTH-1:0]  cnt_q, cnt_d;
    logic                    dir_down_q, dir_down_d;
    logic [1:0]              mode_q, mode_d;
    logic [ACCUM_LENGTH-1:0] fstart_q, fstart_d;
    logic [ACCUM_LENGTH-1:0] fstop_q, fstop_d;
    logic [ACCUM_LENGTH-1:0] fstep_q, fstep_d;
    logic [DWELL_WIDTH-1:0]  dwell_q, dwell_d;

    logic [ACCUM_LENGTH:0]   up_sum;
    logic                    up_fits;
    logic [ACCUM_LENGTH-1:0] dn_val;
    logic                    dn_fits;
    logic [DWELL_WIDTH-1:0]  dwell_eff;
    logic                    cfg_ok;

    // One extra bit on the sum so a step past the top of the range never wraps.
    assign up_sum    = {1'b0, freq_q} + {1'b0, fstep_q};
    assign up_fits   = up_sum <= {1'b0, fstop_q};
    assign dn_val    = freq_q - fstep_q;
    assign dn_fits   = (freq_q >= fstep_q) && (dn_val >= fstart_q);
    assign dwell_eff = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
    assign cfg_ok    = (ctrl_io.f_step_in != '0) && (ctrl_io.f_start_in <= ctrl_io.f_stop_in);

    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        upd_d      = 1'b0;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        mode_d     = mode_q;
        fstart_d   = fstart_q;
        fstop_d    = fstop_q;
        fstep_d    = fstep_q;
        dwell_d    = dwell_q;

        unique case (state_q)
            StIdle: begin
                if (ctrl_io.start_in) begin
                    if (cfg_ok) begin
                        mode_d   = ctrl_io.mode_in;
                        fstart_d = ctrl_io.f_start_in;
                        fstop_d  = ctrl_io.f_stop_in;
                        fstep_d  = ctrl_io.f_step_in;
                        dwell_d  = ctrl_io.dwell_in;
                        state_d  = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (ctrl_io.stop_in) begin
                    state_d = StIdle;
                end else begin
                    freq_d     = fstart_q;
                    upd_d      = 1'b1;
                    cnt_d      = dwell_eff;
                    dir_down_d = 1'b0;
                    state_d    = StDwell;
                end
            end
            StDwell: begin
                if (ctrl_io.stop_in) begin
                    state_d = StIdle;
                end else if (ctrl_io.tick_in) begin
                    if (cnt_q <= DWELL_WIDTH'(1)) begin
                        cnt_d   = '0;
                        state_d = StStep;
                    end else begin
                        cnt_d = cnt_q - DWELL_WIDTH'(1);
                    end
                end
            end
            StStep: begin
                if (ctrl_io.stop_in) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = dwell_eff;
                    state_d = StDwell;
                    if (!dir_down_q) begin
                        if (up_fits) begin
                            freq_d = up_sum[ACCUM_LENGTH-1:0];
                            upd_d  = 1'b1;
                        end else begin
                            case (mode_q)
                                2'b01: begin
                                    freq_d = fstart_q;
                                    upd_d  = 1'b1;
                                end
                                // Triangle: turn around; if that also leaves the range, hold.
                                2'b10: begin
                                    if (dn_fits) begin
                                        freq_d     = dn_val;
                                        upd_d      = 1'b1;
                                        dir_down_d = 1'b1;
                                    end
                                end
                                default: state_d = StDone;
                            endcase
                        end
                    end else if (dn_fits) begin
                        freq_d = dn_val;
                        upd_d  = 1'b1;
                    end else begin
                        dir_down_d = 1'b0;
                        if (up_fits) begin
                            freq_d = up_sum[ACCUM_LENGTH-1:0];
                            upd_d  = 1'b1;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            freq_q     <= '0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
            mode_q     <= '0;
            fstart_q   <= '0;
            fstop_q    <= '0;
            fstep_q    <= '0;
            dwell_q    <= '0;
        end else begin
            state_q    <= state_d;
            freq_q     <= freq_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            dir_down_q <= dir_down_d;
            mode_q     <= mode_d;
            fstart_q   <= fstart_d;
            fstop_q    <= fstop_d;
            fstep_q    <= fstep_d;
            dwell_q    <= dwell_d;
        end
    end

    assign ctrl_io.freq_out     = freq_q;
    assign ctrl_io.freq_upd_out = upd_q;
    assign ctrl_io.err_out      = err_q;
    assign ctrl_io.busy_out     = (state_q == StLoad) || (state_q == StDwell) ||
                                  (state_q == StStep);
    assign ctrl_io.done_out     = (state_q == StDone);
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Randomized bench for freq_sweep_ctrl against a point-list / tick-count model of the sweep.
module tb_freq_sweep_ctrl;
    localparam int AW = 24;
    localparam int DW = 16;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    longint unsigned model_freq = 0;

    always #5 clk_in = ~clk_in;

    freq_sweep_ctrl_if #(.ACCUM_LENGTH(AW), .DWELL_WIDTH(DW)) bus ();

    freq_sweep_ctrl #(.ACCUM_LENGTH(AW), .DWELL_WIDTH(DW)) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .ctrl_io (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic upd, input logic done,
                              input logic busy, input logic err);
        check_eq({tag, ".freq"}, 64'(bus.freq_out), model_freq);
        check_eq({tag, ".upd"},  64'(bus.freq_upd_out), 64'(upd));
        check_eq({tag, ".done"}, 64'(bus.done_out), 64'(done));
        check_eq({tag, ".busy"}, 64'(bus.busy_out), 64'(busy));
        check_eq({tag, ".err"},  64'(bus.err_out), 64'(err));
    endtask

    task automatic drive_idle();
        bus.start_in = 1'b0;
        bus.stop_in  = 1'b0;
        bus.tick_in  = 1'b0;
    endtask

    task automatic scramble_cfg();
        bus.mode_in    = 2'($urandom);
        bus.f_start_in = AW'($urandom);
        bus.f_stop_in  = AW'($urandom);
        bus.f_step_in  = AW'($urandom);
        bus.dwell_in   = DW'($urandom);
    endtask

    // Sweep points are start + p*step, p in 0..n; the mode picks the order of p.
    function automatic bit has_point(input int mode, input longint unsigned n, input int idx);
        case (mode)
            1:       return 1'b1;
            2:       return (n > 0) || (idx == 0);
            default: return longint'(idx) <= longint'(n);
        endcase
    endfunction

    function automatic longint unsigned point_val(input int mode, input longint unsigned u0,
                                                  input longint unsigned st,
                                                  input longint unsigned n, input int idx);
        longint unsigned p;
        if (mode == 1) begin
            p = longint'(idx) % (n + 1);
        end else if (mode == 2 && n > 0) begin
            p = longint'(idx) % (2 * n);
            if (p > n) p = 2 * n - p;
        end else begin
            p = longint'(idx);
        end
        return u0 + p * st;
    endfunction

    task automatic run_sweep(input int mode, input longint unsigned fs, input longint unsigned fe,
                             input longint unsigned fst, input longint unsigned dw,
                             input int tick_pct, input int ncyc, input int stop_at);
        longint unsigned n;
        int  dwe, resume, idx, cnt, stop_k;
        bit  in_dwell, exp_upd, exp_done, tk, stp;
        logic [AW-1:0] fs_w, fe_w, fst_w;
        n        = (fe - fs) / fst;
        dwe      = (dw == 0) ? 1 : int'(dw);
        stop_k   = (stop_at > 0 && stop_at < ncyc) ? stop_at : ncyc;
        resume   = 2;
        idx      = 0;
        cnt      = 0;
        in_dwell = 1'b0;
        fs_w     = fs[AW-1:0];
        fe_w     = fe[AW-1:0];
        fst_w    = fst[AW-1:0];
        check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.start_in   = 1'b1;
        bus.stop_in    = 1'($urandom_range(0, 1));
        bus.tick_in    = 1'b1;
        bus.mode_in    = 2'(mode);
        bus.f_start_in = fs_w;
        bus.f_stop_in  = fe_w;
        bus.f_step_in  = fst_w;
        bus.dwell_in   = DW'(dw);
        step_clk();
        for (int k = 1; k <= ncyc; k++) begin
            exp_upd  = 1'b0;
            exp_done = 1'b0;
            if (k == resume) begin
                if (has_point(mode, n, idx)) begin
                    exp_upd    = 1'b1;
                    model_freq = point_val(mode, fs, fst, n, idx);
                    idx++;
                end else if (mode != 1 && mode != 2) begin
                    exp_done = 1'b1;
                end
                in_dwell = !exp_done;
                cnt      = 0;
            end
            check_outs("sweep", exp_upd, exp_done, !exp_done, 1'b0);
            if (exp_done) begin
                drive_idle();
                step_clk();
                check_outs("after_done", 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            tk           = ($urandom_range(0, 99) < tick_pct);
            stp          = (k == stop_k);
            bus.tick_in  = tk;
            bus.stop_in  = stp;
            bus.start_in = 1'b0;
            if (k == 1) scramble_cfg();
            if (!stp && $urandom_range(0, 7) == 0) begin
                bus.start_in = 1'b1;
                scramble_cfg();
            end
            step_clk();
            if (stp) begin
                drive_idle();
                check_outs("after_stop", 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (in_dwell && tk) begin
                cnt++;
                if (cnt == dwe) begin
                    in_dwell = 1'b0;
                    resume   = k + 2;
                end
            end
        end
    endtask

    task automatic run_err(input longint unsigned fs, input longint unsigned fe,
                           input longint unsigned fst);
        bus.start_in   = 1'b1;
        bus.stop_in    = 1'b0;
        bus.mode_in    = 2'($urandom);
        bus.f_start_in = fs[AW-1:0];
        bus.f_stop_in  = fe[AW-1:0];
        bus.f_step_in  = fst[AW-1:0];
        bus.dwell_in   = DW'($urandom_range(0, 3));
        step_clk();
        drive_idle();
        check_outs("err_pulse", 1'b0, 1'b0, 1'b0, 1'b1);
        step_clk();
        check_outs("err_clear", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        longint unsigned fs, fe, fst;
        drive_idle();
        scramble_cfg();
        rst_in = 1'b1;
        step_clk();
        step_clk();
        rst_in = 1'b0;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        run_sweep(0, 100, 400, 100, 2, 100, 200, -1);
        run_sweep(0, 0, 250, 100, 1, 100, 200, -1);
        run_sweep(1, 0, 200, 100, 1, 100, 60, -1);
        run_sweep(2, 100, 300, 100, 1, 80, 80, -1);
        run_sweep(2, 100, 100, 100, 1, 100, 40, -1);
        run_sweep(0, 64'hFFFF00, 64'hFFFFFF, 64'h100, 1, 100, 50, -1);
        run_sweep(3, 10, 50, 20, 0, 100, 100, -1);
        run_sweep(0, 100, 400, 100, 3, 100, 200, 5);
        run_err(5, 10, 0);
        run_err(20, 10, 1);

        // Reset mid-sweep clears every output.
        bus.start_in   = 1'b1;
        bus.mode_in    = 2'b01;
        bus.f_start_in = AW'(500);
        bus.f_stop_in  = AW'(900);
        bus.f_step_in  = AW'(50);
        bus.dwell_in   = DW'(1);
        step_clk();
        bus.start_in = 1'b0;
        bus.tick_in  = 1'b1;
        for (int i = 0; i < 6; i++) step_clk();
        rst_in = 1'b1;
        step_clk();
        rst_in = 1'b0;
        drive_idle();
        model_freq = 0;
        check_outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        step_clk();
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                fs = 64'hFFFFFF - 64'($urandom_range(0, 2000));
                fe = fs + 64'($urandom_range(0, 32'(64'hFFFFFF - fs)));
            end else begin
                fs = 64'($urandom_range(0, 999));
                fe = fs + 64'($urandom_range(0, 799));
            end
            fst = 64'($urandom_range(1, 300));
            if ($urandom_range(0, 5) == 0) begin
                run_err(fs + 1 + 64'($urandom_range(0, 50)), fs, fst);
            end
            run_sweep(int'($urandom_range(0, 3)), fs, fe, fst, 64'($urandom_range(0, 3)),
                      int'($urandom_range(30, 100)), 300,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL have parameter ACCUM_LENGTH, default 24, meaning width of every tuning word.
REQ-002 SHALL have parameter DWELL_WIDTH, default 16, meaning width of the dwell counter and dwell_in.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk_in  input  1  system clock; all state updates on rising edge.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 start_in  input  1  request to begin a sweep; sampled every cycle.
REQ-007 stop_in  input  1  abort of a running sweep.
REQ-008 tick_in  input  1  sample-rate enable; one dwell count per high cycle.
REQ-009 mode_in  input  2  sweep mode: 00 single up-ramp, 01 repeating up-ramp, 10 triangle, 11 treated as 00.
REQ-010 f_start_in  input  ACCUM_LENGTH  first tuning word (unsigned).
REQ-011 f_stop_in  input  ACCUM_LENGTH  upper-bound tuning word (unsigned).
REQ-012 f_step_in  input  ACCUM_LENGTH  step size (unsigned).
REQ-013 dwell_in  input  DWELL_WIDTH  tick_in count per frequency point; 0 treated as 1.
REQ-014 freq_out  output  ACCUM_LENGTH  current tuning word to the phase accumulator.
REQ-015 freq_upd_out  output  1  one-cycle pulse in the cycle freq_out takes a newly loaded or stepped value.
REQ-016 busy_out  output  1  high while a sweep runs.
REQ-017 done_out  output  1  one-cycle pulse when a single-ramp sweep completes.
REQ-018 err_out  output  1  one-cycle pulse on a rejected start.

Function
REQ-019 SHALL implement states IDLE, LOAD, DWELL, STEP, DONE; busy_out SHALL be 1 exactly in LOAD, DWELL and STEP.
REQ-020 IDLE: start_in=1 with f_step_in!=0 and f_start_in<=f_stop_in SHALL latch all config inputs and go to LOAD; otherwise err_out SHALL pulse the next cycle and state stays IDLE.
REQ-021 Config inputs SHALL be sampled only at an accepted start; later changes SHALL have no effect until the next start.
REQ-022 start_in while busy_out=1 SHALL be ignored.
REQ-023 LOAD (1 cycle): freq_out<=f_start, freq_upd_out pulses, dwell counter<=max(dwell,1), direction<=up, next state DWELL. freq_out=f_start and freq_upd_out=1 appear 2 cycles after the start_in cycle.
REQ-024 DWELL: each tick_in=1 SHALL decrement the counter; the tick that brings it to 0 SHALL move to STEP; tick_in during STEP or LOAD SHALL be ignored.
REQ-025 STEP (1 cycle): SHALL compute next value in ACCUM_LENGTH+1 bits with no wrap-around; the updated freq_out appears the cycle after STEP with freq_upd_out=1; dwell counter reloads.
REQ-026 Up direction, f+step<=stop: freq_out<=f+step, return to DWELL.
REQ-027 Up direction, f+step>stop: mode 00/11 -> DONE with freq_out held; mode 01 -> freq_out<=start, DWELL; mode 10 -> direction<=down, apply the down rule.
REQ-028 Down direction, f-step>=start (f>=step required): freq_out<=f-step, DWELL; otherwise direction<=up, freq_out<=f+step if <=stop.
REQ-029 If a reversed step also leaves [start,stop], freq_out SHALL hold, freq_upd_out SHALL stay 0, and the sweep continues in DWELL.
REQ-030 DONE (1 cycle): done_out=1, busy_out=0, then IDLE; freq_out retains last value.
REQ-031 stop_in=1 in LOAD/DWELL/STEP SHALL force IDLE next cycle with stop taking priority over tick/step; freq_out held, done_out and freq_upd_out stay 0.
REQ-032 stop_in in IDLE SHALL have no effect; start_in and stop_in together in IDLE SHALL start a sweep.

Reset
REQ-033 rst_in=1 SHALL, at the next edge, force state IDLE, freq_out=0, freq_upd_out=0, busy_out=0, done_out=0, err_out=0, dwell counter=0, direction=up, config registers=0.
REQ-034 Reset SHALL override all other inputs, including mid-sweep, and SHALL produce no done_out pulse.

Verification
REQ-035 mode 00, start=100, stop=400, step=100, dwell=2, tick_in=1 always -> freq_out 100,200,300,400, each held 3 cycles; then done_out pulse, busy_out=0, freq_out=400.
REQ-036 mode 00, start=0, stop=250, step=100 -> 0,100,200, then done_out; 250 is never output.
REQ-037 mode 01, start=0, stop=200, step=100 -> 0,100,200,0,100,...; done_out never asserted.
REQ-038 mode 10, start=100, stop=300, step=100 -> 100,200,300,200,100,200,...; start=stop=100 -> freq_out holds 100, freq_upd_out only at LOAD.
REQ-039 mode 00, start=0xFFFF00, stop=0xFFFFFF, step=0x000100 -> 0xFFFF00 only, then done_out; freq_out never wraps to 0.
REQ-040 stop_in mid-DWELL -> IDLE next cycle, busy_out=0, no done_out, freq_out held; step=0 start -> err_out pulse, busy_out stays 0; rst_in mid-sweep -> all outputs 0.
